// File: rtl/bsg_sdi_tx_pkg.sv
// Shared constants for the source-synchronous SDI transmitter: default geometry and FSM state codes.
package bsg_sdi_tx_pkg;

    localparam int packet_width_def_lp     = 80;
    localparam int channel_width_def_lp    = 8;
    localparam int credits_def_lp          = 16;
    localparam int token_decimation_def_lp = 4;

    typedef logic [1:0] state_t;

    localparam state_t state_idle_lp  = 2'd0;
    localparam state_t state_send_lp  = 2'd1;
    localparam state_t state_stall_lp = 2'd2;

endpackage

// File: rtl/bsg_sdi_tx_if.sv
// Host-side packet handshake of the SDI transmitter (valid/ready with a full-width packet).
interface bsg_sdi_tx_if
    import bsg_sdi_tx_pkg::*;
    #(parameter int width_p = packet_width_def_lp);

    logic [width_p-1:0] data;
    logic               v;
    logic               ready;

    modport master (output data, output v, input ready);
    modport slave  (input data, input v, output ready);

endinterface

// File: rtl/bsg_sdi_tx_token_sync.sv
// Two-flop synchronizer on the receiver's credit toggle line; emits a 1-cycle pulse per edge of either polarity.
module bsg_sdi_tx_token_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic toggle_i,
    output logic pulse_o
);

    logic sync1_q, sync2_q, last_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            sync1_q <= toggle_i;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q ^ last_q;

endmodule

// File: rtl/bsg_sdi_tx.sv
// Credit-based packet serializer onto a source-synchronous line.
// Optional macro BSG_SDI_TX_IDLE_CLK_GATE_EN: line clock toggles only while beats are driven.
//
//  state | meaning
//  IDLE  | no packet held, ready for a new one
//  SEND  | packet held, driving one beat per cycle
//  STALL | packet held, waiting for credits
module bsg_sdi_tx
    import bsg_sdi_tx_pkg::*;
    #(parameter int packet_width_p     = packet_width_def_lp,
      parameter int channel_width_p    = channel_width_def_lp,
      parameter int credits_p          = credits_def_lp,
      parameter int token_decimation_p = token_decimation_def_lp)
    (
    input  logic                       core_clk_i,
    input  logic                       async_reset_i,
    input  logic [packet_width_p-1:0]  data_i,
    input  logic                       v_i,
    output logic                       ready_o,
    output logic                       clk_tline_o,
    output logic                       valid_tline_o,
    output logic [channel_width_p-1:0] data_tline_o,
    input  logic                       token_clk_tline_i,
    output logic                       credit_err_o
);

    localparam int beats_lp    = packet_width_p / channel_width_p;
    localparam int beat_w_lp   = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam int credit_w_lp = $clog2(credits_p + 1);

    state_t                     state_q, state_d;
    logic [packet_width_p-1:0]  shift_q, shift_d;
    logic [beat_w_lp-1:0]       beat_q, beat_d;
    logic [credit_w_lp-1:0]     credits_q, credits_d;
    logic [channel_width_p-1:0] data_q, data_d;
    logic                       ready_q, ready_d;
    logic                       valid_q, valid_d;
    logic                       clk_q, clk_d;
    logic                       err_q, err_d;
    logic                       token_pulse, busy, emit, last_beat, accept;
    logic [31:0]                credit_sum;

    bsg_sdi_tx_token_sync token_sync (
        .clk_i   (core_clk_i),
        .rst_i   (async_reset_i),
        .toggle_i(token_clk_tline_i),
        .pulse_o (token_pulse)
    );

    // A credit returning this cycle may be spent this cycle, so a stall never waits on the counter register.
    assign busy      = (state_q == state_send_lp) || (state_q == state_stall_lp);
    assign emit      = busy && ((credits_q != '0) || token_pulse);
    assign last_beat = (beat_q == beat_w_lp'(beats_lp - 1));
    assign ready_o   = ready_q || (emit && last_beat);
    assign accept    = v_i && ready_o;

    assign credit_sum = 32'(credits_q)
                      + (token_pulse ? 32'(token_decimation_p) : 32'd0)
                      - (emit ? 32'd1 : 32'd0);

    always_comb begin
        credits_d = credit_sum[credit_w_lp-1:0];
        err_d     = err_q;
        if (credit_sum > 32'(credits_p)) begin
            credits_d = credit_w_lp'(credits_p);
            err_d     = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        beat_d  = beat_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            state_idle_lp: begin
                if (accept) begin
                    shift_d = data_i;
                    beat_d  = '0;
                    state_d = state_send_lp;
                end
            end
            state_send_lp, state_stall_lp: begin
                if (emit) begin
                    valid_d = 1'b1;
                    data_d  = shift_q[channel_width_p-1:0];
                    shift_d = shift_q >> channel_width_p;
                    beat_d  = beat_q + 1'b1;
                    state_d = state_send_lp;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = state_idle_lp;
                        if (accept) begin
                            shift_d = data_i;
                            state_d = state_send_lp;
                        end
                    end
                end else begin
                    state_d = state_stall_lp;
                end
            end
            default: state_d = state_idle_lp;
        endcase
        ready_d = (state_d == state_idle_lp);
    end

`ifdef BSG_SDI_TX_IDLE_CLK_GATE_EN
    assign clk_d = clk_q ^ emit;
`else
    assign clk_d = ~clk_q;
`endif

    always_ff @(posedge core_clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            state_q   <= state_idle_lp;
            shift_q   <= '0;
            beat_q    <= '0;
            credits_q <= credit_w_lp'(credits_p);
            data_q    <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            clk_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            beat_q    <= beat_d;
            credits_q <= credits_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            clk_q     <= clk_d;
            err_q     <= err_d;
        end
    end

    assign clk_tline_o   = clk_q;
    assign valid_tline_o = valid_q;
    assign data_tline_o  = data_q;
    assign credit_err_o  = err_q;

endmodule

// File: tb/tb_bsg_sdi_tx.sv
// Bench for bsg_sdi_tx: directed credit/stall/reset scenarios plus random traffic against a beat-queue model.
module tb_bsg_sdi_tx;

    localparam int PW  = 80;
    localparam int CW  = 8;
    localparam int NB  = PW / CW;
    localparam int CR  = 16;
    localparam int DEC = 4;

    logic          core_clk = 1'b0;
    logic          rst      = 1'b1;
    logic          tok      = 1'b0;
    logic          clk_tline, valid_tline, err;
    logic [CW-1:0] data_tline;

    bsg_sdi_tx_if #(.width_p(PW)) host ();

    bsg_sdi_tx #(.packet_width_p(PW), .channel_width_p(CW), .credits_p(CR), .token_decimation_p(DEC)) dut (
        .core_clk_i       (core_clk),
        .async_reset_i    (rst),
        .data_i           (host.data),
        .v_i              (host.v),
        .ready_o          (host.ready),
        .clk_tline_o      (clk_tline),
        .valid_tline_o    (valid_tline),
        .data_tline_o     (data_tline),
        .token_clk_tline_i(tok),
        .credit_err_o     (err)
    );

    always #5 core_clk = ~core_clk;

    int n_checks = 0, n_fail = 0;
    int cyc = 0, acc_cyc = 0;
    int beats_total = 0, beats_base = 0, tog_cnt = 0, tog_base = 0;
    logic [CW-1:0] exp_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rel();
        return beats_total - beats_base;
    endfunction

    always @(posedge core_clk) cyc <= cyc + 1;

    // Model: beats leave in packet order, LSB slice first, and never outrun credits granted by toggles.
    always @(negedge core_clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (valid_tline) begin
            beats_total++;
            if (exp_q.size() == 0) chk("beat_extra", exp_q.size(), 1);
            else                   chk("beat_data", data_tline, exp_q.pop_front());
            chk("credit_bound", rel() <= CR + DEC * (tog_cnt - tog_base), 1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] p);
        int n = 0;
        host.data = p;
        host.v    = 1'b1;
        while (!host.ready && n < 3000) begin
            cycles(1);
            n++;
        end
        if (!host.ready) begin
            chk("send_ready", host.ready, 1);
            host.v = 1'b0;
            return;
        end
        for (int i = 0; i < NB; i++) exp_q.push_back(p[i*CW +: CW]);
        @(posedge core_clk);
        #1;
        acc_cyc = cyc;
        host.v  = 1'b0;
    endtask

    task automatic toggle(input int settle);
        @(negedge core_clk);
        tok = ~tok;
        tog_cnt++;
        cycles(settle);
    endtask

    task automatic wait_beats(input int target, input int max_cyc);
        for (int i = 0; i < max_cyc && rel() < target; i++) cycles(1);
    endtask

    task automatic do_reset();
        @(negedge core_clk);
        rst = 1'b1;
        tok = 1'b0;
        host.v = 1'b0;
        cycles(2);
        @(negedge core_clk);
        rst = 1'b0;
        tog_base   = tog_cnt;
        beats_base = beats_total;
        cycles(1);
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] p0;
        int k, first, last, cnt, changes;
        logic prev_clk;

        host.v = 1'b0;
        host.data = '0;
        cycles(3);
        chk("rst_ready", host.ready, 0);
        chk("rst_valid", valid_tline, 0);
        chk("rst_data", data_tline, 0);
        chk("rst_clk", clk_tline, 0);
        chk("rst_err", err, 0);
        @(negedge core_clk);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", host.ready, 0);
        cycles(1);
        chk("ready_first_edge", host.ready, 1);

        // Known packet: beats 00..09 on consecutive cycles, one cycle after accept.
        p0 = 80'h0908_0706_0504_0302_0100;
        send(p0);
        @(negedge core_clk);
        chk("first_beat_latency", valid_tline, 0);
        for (int i = 0; i < NB; i++) begin
            @(negedge core_clk);
            chk("p0_valid", valid_tline, 1);
            chk("p0_data", data_tline, i);
            if (i == 0) chk("p0_ready_mid", host.ready, 0);
            if (i == NB - 1) chk("p0_ready_last", host.ready, 1);
        end
        @(negedge core_clk);
        chk("p0_done_valid", valid_tline, 0);
        send(rand_pkt());
        cycles(25);
        chk("credits_left_6", rel(), CR);
        chk("stall_valid", valid_tline, 0);

        // Three back-to-back packets, no returns: 16 beats, stall, then 4 beats per toggle.
        do_reset();
        fork
            begin send(rand_pkt()); send(rand_pkt()); send(rand_pkt()); end
        join_none
        wait_beats(CR, 100);
        cycles(10);
        chk("b2b_stall_count", rel(), CR);
        chk("b2b_stall_valid", valid_tline, 0);
        @(negedge core_clk);
        tok = ~tok;
        tog_cnt++;
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge core_clk);
            if (valid_tline) begin k = i; break; end
        end
        chk("token_latency", k, 3);
        cycles(15);
        chk("token_4_beats", rel(), CR + DEC);
        chk("stall_again", valid_tline, 0);
        repeat (3) toggle(6);
        wait_beats(3 * NB, 100);
        cycles(3);
        chk("b2b_all_beats", rel(), 3 * NB);
        chk("b2b_queue_empty", exp_q.size(), 0);

        // Token pulse lands on the beat that spends the last credit: no stall cycle.
        do_reset();
        send(rand_pkt());
        fork
            send(rand_pkt());
        join_none
        first = -1; last = -1; cnt = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge core_clk);
            if (valid_tline) begin
                if (first < 0) first = i;
                last = i;
                cnt++;
            end
            if (i == 14) begin tok = ~tok; tog_cnt++; end
        end
        chk("nostall_count", cnt, 2 * NB);
        chk("nostall_span", last - first, 2 * NB - 1);

        // Credits are now 0: three returns reach 12, a fourth reaches 16 exactly, a fifth overflows.
        repeat (3) toggle(6);
        chk("err_at_12", err, 0);
        toggle(6);
        chk("err_at_16", err, 0);
        toggle(6);
        chk("err_overflow", err, 1);
        cycles(10);
        chk("err_sticky", err, 1);
        beats_base = beats_total;
        fork
            begin send(rand_pkt()); send(rand_pkt()); end
        join_none
        cycles(40);
        chk("saturated_16", rel(), CR);
        toggle(10);
        chk("sat_drain", rel(), 2 * NB);
        chk("err_still_set", err, 1);
        do_reset();
        chk("err_cleared", err, 0);

        // Reset in the middle of a packet discards it.
        send(rand_pkt());
        wait_beats(6, 50);
        rst = 1'b1;
        #1;
        chk("midrst_valid", valid_tline, 0);
        chk("midrst_ready", host.ready, 0);
        cycles(2);
        @(negedge core_clk);
        rst = 1'b0;
        tog_base   = tog_cnt;
        beats_base = beats_total;
        #1;
        chk("midrst_ready_hold", host.ready, 0);
        cycles(1);
        chk("midrst_ready_up", host.ready, 1);
        fork
            begin send(rand_pkt()); send(rand_pkt()); end
        join_none
        cycles(40);
        chk("midrst_credits_16", rel(), CR);
        do_reset();

        // Idle line clock behaviour.
        @(negedge core_clk);
        prev_clk = clk_tline;
        changes = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge core_clk);
            if (clk_tline != prev_clk) changes++;
            prev_clk = clk_tline;
        end
`ifdef BSG_SDI_TX_IDLE_CLK_GATE_EN
        chk("idle_clk_toggles", changes, 0);
`else
        chk("idle_clk_toggles", changes, 20);
`endif

        // Random packets, gaps and credit returns.
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    cycles($urandom_range(0, 3));
                    send(rand_pkt());
                end
            end
            begin
                for (int g = 0; g < 200 && rel() < 6 * NB; g++)
                    toggle($urandom_range(2, 12));
            end
        join
        cycles(10);
        chk("rand_all_beats", rel(), 6 * NB);
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
